register_universal: RTL and testbench

Parametrised multi-mode register, the successor to the fixed 8-bit clearable register. It holds a WIDTH-bit word that can be held, loaded per byte lane, shifted, rotated, incremented or decremented, and it reports a registered carry/borrow flag and a zero flag. It is used as the general-purpose datapath register in the COD designs (accumulators, shift/rotate units, loop counters) in place of hand-instantiated per-bit flops.

---
 rtl/register_pkg.sv | 26 ++
 rtl/register_lane.sv | 26 ++
 rtl/register_universal.sv | 125 ++++++++++++
 tb/tb_register_universal.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared definitions for the universal register.
// Holds the operation encodings carried on the 3-bit mode port, the byte-lane
// width, and a helper that derives the lane count from a word width.
package register_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INC  = 3'd6,
    MODE_DEC  = 3'd7
  } mode_e;

  localparam int LANE_W = 8;

  // Byte-lane count for the default 16-bit word.
  localparam int DEFAULT_LANES = 16 / LANE_W;

  function automatic int lane_count(input int width);
    return width / LANE_W;
  endfunction

endpackage

// File: rtl/register_lane.sv
// One 8-bit slice of the universal register.
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous active-low reset, loads RESET_VAL
//   load  - lane update enable for this edge
//   next  - value captured when load is high
//   q     - lane contents
module register_lane #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] next,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= next;
    end
  end

endmodule

// File: rtl/register_universal.sv
// Parametrised multi-mode datapath register: hold, per-byte load, shift,
// rotate, increment and decrement, with a registered carry/borrow/shift-out
// flag and a combinational zero flag.
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous active-low reset (q <= RESET_VAL, co <= 0)
//   en    - operation enable; low holds all state
//   mode  - operation select (register_pkg::mode_e encodings)
//   d     - parallel load data
//   be    - byte-lane load enables, used only in LOAD
//   sin   - serial input for SHL/SHR
//   q     - register contents
//   co    - carry, borrow or shifted-out bit from the last operation
//   zero  - high when q is zero
module register_universal
  import register_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH/8-1:0] be,
  input  logic               sin,
  output logic [WIDTH-1:0]   q,
  output logic               co,
  output logic               zero
);

  localparam int LANES = lane_count(WIDTH);

  mode_e            op;
  logic [WIDTH-1:0] q_next;
  logic             co_next;
  logic [LANES-1:0] lane_load;

  assign op = mode_e'(mode);

  // Next word and flag for every operation. LOAD presents d to all lanes;
  // the per-lane enables decide which lanes actually take it.
  always_comb begin
    q_next  = q;
    co_next = co;
    case (op)
      MODE_HOLD: begin
        q_next  = q;
        co_next = co;
      end
      MODE_LOAD: begin
        q_next  = d;
        co_next = 1'b0;
      end
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        co_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        co_next = q[0];
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        co_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        co_next = q[0];
      end
      MODE_INC: begin
        {co_next, q_next} = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
      end
      MODE_DEC: begin
        q_next  = q - {{(WIDTH-1){1'b0}}, 1'b1};
        co_next = (q == '0);
      end
      default: begin
        q_next  = q;
        co_next = co;
      end
    endcase
  end

  // Lane enables: none while disabled or holding, be in LOAD, all otherwise.
  always_comb begin
    lane_load = '0;
    if (en) begin
      case (op)
        MODE_HOLD: lane_load = '0;
        MODE_LOAD: lane_load = be;
        default:   lane_load = '1;
      endcase
    end
  end

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      register_lane #(
        .RESET_VAL(RESET_VAL[8*i +: 8])
      ) u_lane (
        .clk  (clk),
        .clear(clear),
        .load (lane_load[i]),
        .next (q_next[8*i +: 8]),
        .q    (q[8*i +: 8])
      );
    end
  endgenerate

  // co is updated by every enabled operation except HOLD; a LOAD with no
  // lanes selected still clears it.
  always_ff @(posedge clk) begin
    if (!clear) begin
      co <= 1'b0;
    end else if (en && (op != MODE_HOLD)) begin
      co <= co_next;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_register_universal.sv
module tb_register_universal;
  import register_pkg::*;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  d = '0;
  logic [W/8-1:0] be = '0;
  logic          sin = 1'b0;
  logic [W-1:0]  q;
  logic          co;
  logic          zero;

  int tests = 0;
  int fails = 0;

  register_universal #(
    .WIDTH    (W),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .en   (en),
    .mode (mode),
    .d    (d),
    .be   (be),
    .sin  (sin),
    .q    (q),
    .co   (co),
    .zero (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic c, input logic e, input logic [2:0] m,
                      input logic [15:0] dv, input logic [1:0] bv, input logic s);
    clear = c;
    en    = e;
    mode  = m;
    d     = dv;
    be    = bv;
    sin   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] qe,
                       input logic ce, input logic ze);
    tests++;
    assert (q === qe) else begin
      fails++;
      $error("FAIL %s q: got %h expected %h", tag, q, qe);
    end
    tests++;
    assert (co === ce) else begin
      fails++;
      $error("FAIL %s co: got %b expected %b", tag, co, ce);
    end
    tests++;
    assert (zero === ze) else begin
      fails++;
      $error("FAIL %s zero: got %b expected %b", tag, zero, ze);
    end
  endtask

  initial begin
    #2;
    // Reset wins over an enabled INC.
    step(1'b0, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("reset", 16'hA5A5, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("inc_after_reset", 16'hA5A6, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_HOLD, 16'hFFFF, 2'b11, 1'b1);
    check("hold", 16'hA5A6, 1'b0, 1'b0);

    // Byte-lane load.
    step(1'b1, 1'b1, MODE_LOAD, 16'h1234, 2'b11, 1'b0);
    check("load_full", 16'h1234, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_LOAD, 16'hABCD, 2'b10, 1'b0);
    check("load_hi_lane", 16'hAB34, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_LOAD, 16'h5678, 2'b01, 1'b0);
    check("load_lo_lane", 16'hAB78, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_LOAD, 16'h0000, 2'b00, 1'b0);
    check("load_no_lane", 16'hAB78, 1'b0, 1'b0);

    // LOAD with be=00 still clears co.
    step(1'b1, 1'b1, MODE_LOAD, 16'hFFFF, 2'b11, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("inc_wrap_a", 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b1, MODE_LOAD, 16'h1111, 2'b00, 1'b0);
    check("load_be0_clr_co", 16'h0000, 1'b0, 1'b1);

    // Shift and rotate.
    step(1'b1, 1'b1, MODE_LOAD, 16'h8001, 2'b11, 1'b0);
    check("load_8001", 16'h8001, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_SHL, 16'h0000, 2'b00, 1'b1);
    check("shl", 16'h0003, 1'b1, 1'b0);
    step(1'b1, 1'b1, MODE_SHR, 16'h0000, 2'b00, 1'b0);
    check("shr", 16'h0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, MODE_ROR, 16'h0000, 2'b00, 1'b0);
    check("ror", 16'h8000, 1'b1, 1'b0);
    step(1'b1, 1'b1, MODE_ROL, 16'h0000, 2'b00, 1'b0);
    check("rol", 16'h0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, MODE_SHL, 16'h0000, 2'b00, 1'b0);
    check("shl_sin0", 16'h0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_SHR, 16'h0000, 2'b00, 1'b1);
    check("shr_sin1", 16'h8001, 1'b0, 1'b0);

    // Wrap-around.
    step(1'b1, 1'b1, MODE_LOAD, 16'hFFFF, 2'b11, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("inc_wrap", 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b1, MODE_DEC, 16'h0000, 2'b00, 1'b0);
    check("dec_borrow", 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, MODE_LOAD, 16'h0001, 2'b11, 1'b0);
    step(1'b1, 1'b1, MODE_DEC, 16'h0000, 2'b00, 1'b0);
    check("dec_to_zero", 16'h0000, 1'b0, 1'b1);

    // Enable low holds q and co.
    step(1'b1, 1'b1, MODE_LOAD, 16'hFFFF, 2'b11, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, MODE_LOAD, 16'h5555, 2'b11, 1'b0);
      check("en_low_hold", 16'h0000, 1'b1, 1'b1);
    end
    step(1'b1, 1'b1, MODE_LOAD, 16'h5555, 2'b11, 1'b0);
    check("en_high_load", 16'h5555, 1'b0, 1'b0);

    // Reset also wins while en is low.
    step(1'b0, 1'b0, MODE_HOLD, 16'h0000, 2'b00, 1'b0);
    check("reset_en_low", 16'hA5A5, 1'b0, 1'b0);

    // Reset mid-stream during counting.
    step(1'b1, 1'b1, MODE_LOAD, 16'h0000, 2'b11, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_1", 16'h0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_2", 16'h0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_3", 16'h0003, 1'b0, 1'b0);
    step(1'b0, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_reset", 16'hA5A5, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_resume_1", 16'hA5A6, 1'b0, 1'b0);
    step(1'b1, 1'b1, MODE_INC, 16'h0000, 2'b00, 1'b0);
    check("count_resume_2", 16'hA5A7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
